// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss timer controller.
// The packed time value is {minutes, seconds}, each a 6-bit field in 0..59.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam int FIELD_W = 6;
    localparam int TIME_W  = 12;
    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;

    // Field increment that wraps to zero once the field reaches top.
    // Using >= keeps an out-of-range value from ever escaping upward.
    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] top);
        return (v >= top) ? '0 : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Control strobes and display-side outputs of the timer controller.
// The slave modport is the controller's view; master is the driver's view.
interface timer_ctrl_if;
    import timer_pkg::*;

    logic              start_stop;
    logic              clear;
    logic              mode_down;
    logic              inc_min;
    logic              inc_sec;
    logic [TIME_W-1:0] counter_out;
    logic              running;
    logic              alarm;

    modport master (
        output start_stop, clear, mode_down, inc_min, inc_sec,
        input  counter_out, running, alarm
    );

    modport slave (
        input  start_stop, clear, mode_down, inc_min, inc_sec,
        output counter_out, running, alarm
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Holds its count while en is low; clr forces it back to zero.
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign tick    = en & at_last;

    // Next count: clear wins, otherwise advance and roll over only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// mm:ss stopwatch / countdown sequencer feeding the seven-segment decoder.
// Owns the packed time value and the IDLE/RUN/PAUSE/DONE state machine.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic         clk,
    input  logic         nrst,
    timer_ctrl_if.slave  bus
);

    localparam logic [FIELD_W-1:0] MIN_TOP = FIELD_W'(MAX_MIN);

    timer_state_t       state_q, state_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic               mode_q, mode_d;      // 1 = counting down
    logic               running_q, running_d;
    logic               alarm_q, alarm_d;

    logic               tick;
    logic               pre_en;
    logic               pre_clr;
    logic               tick_fin;            // this tick ends the run
    logic               time_zero;

    assign time_zero = (min_q == '0) && (sec_q == '0);

    // The prescaler only advances in RUN; it is parked at zero in IDLE and
    // DONE so every fresh start begins a full period, and holds in PAUSE.
    assign pre_en  = (state_q == RUN);
    assign pre_clr = bus.clear | (state_q == IDLE) | (state_q == DONE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .nrst (nrst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    // Next state, time arithmetic and registered output values.
    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        sec_d    = sec_q;
        mode_d   = mode_q;
        tick_fin = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_stop) begin
                        mode_d = bus.mode_down;
                        // Nothing to count down from: alarm straight away.
                        state_d = (bus.mode_down && time_zero) ? DONE : RUN;
                    end else begin
                        if (bus.inc_min) begin
                            min_d = wrap_inc(min_q, MIN_TOP);
                        end
                        if (bus.inc_sec) begin
                            sec_d = wrap_inc(sec_q, SEC_MAX);
                        end
                    end
                end

                RUN: begin
                    if (tick) begin
                        if (mode_q) begin
                            if (time_zero) begin
                                // Defensive: never borrow below 00:00.
                                tick_fin = 1'b1;
                            end else if (sec_q == '0) begin
                                sec_d = SEC_MAX;
                                min_d = min_q - FIELD_W'(1);
                            end else begin
                                sec_d    = sec_q - FIELD_W'(1);
                                tick_fin = (min_q == '0) && (sec_q == FIELD_W'(1));
                            end
                        end else begin
                            if ((min_q >= MIN_TOP) && (sec_q >= SEC_MAX)) begin
                                // Saturate at the top value and raise the alarm.
                                tick_fin = 1'b1;
                            end else if (sec_q >= SEC_MAX) begin
                                sec_d = '0;
                                min_d = min_q + FIELD_W'(1);
                            end else begin
                                sec_d = sec_q + FIELD_W'(1);
                            end
                        end
                    end
                    // A pause request outranks the tick's state change, but
                    // the tick's time update above still lands.
                    if (bus.start_stop) begin
                        state_d = PAUSE;
                    end else if (tick_fin) begin
                        state_d = DONE;
                    end
                end

                PAUSE: begin
                    if (bus.start_stop) begin
                        state_d = RUN;
                    end
                end

                DONE: begin
                    if (bus.start_stop) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        alarm_d   = (state_d == DONE);
    end

    // State, time and output registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign bus.counter_out = {min_q, sec_q};
    assign bus.running     = running_q;
    assign bus.alarm       = alarm_q;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing controller for the mm:ss seven-segment display path.
- Owns the packed 12-bit time value: minutes in [11:6], seconds in [5:0], each field 0..59. This value drives the existing BCD/segment decoder.
- Implements a stopwatch (count up) and a countdown timer (count down) with set, start/pause, clear and alarm, all paced by an internal 1 Hz prescaler.

Parameters:
- TICK_DIV, 10_000_000: clk cycles per one-second tick. Legal range is 2 or more; simulation uses 4.
- MAX_MIN, 59: maximum minute value, used for count-up saturation and set wrap.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- start_stop  in  1  single-cycle strobe; toggles run/pause
- clear  in  1  single-cycle strobe; returns to IDLE and zeroes time
- mode_down  in  1  1 = countdown, 0 = stopwatch; sampled only in IDLE
- inc_min  in  1  single-cycle strobe; minute +1 in IDLE
- inc_sec  in  1  single-cycle strobe; second +1 in IDLE
- counter_out  out  12  {minutes[5:0], seconds[5:0]} to the decoder
- running  out  1  high in RUN
- alarm  out  1  high in DONE

Behaviour:
- Clock and reset:
  - One clock, clk. Reset nrst is synchronous and active-low.
  - Reset values: state=IDLE, counter_out=0, prescaler=0, running=0, alarm=0, latched mode=0.
  - Reset mid-operation overrides every other input in that cycle.
- Inputs: all strobes are already synchronized and edge-detected upstream. The block does no debouncing.
- State machine: IDLE, RUN, PAUSE, DONE.
  - IDLE:
    - inc_min: minutes +1, wrapping MAX_MIN to 0.
    - inc_sec: seconds +1, wrapping 59 to 0, with no carry into minutes.
    - inc_min and inc_sec together: both fields apply.
    - start_stop: latch mode_down and go to RUN, with prescaler cleared.
    - start_stop in countdown mode with time = 00:00: go directly to DONE.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1; the tick fires in the cycle it equals TICK_DIV-1, then it returns to 0.
    - On tick, counter_out updates in the next edge, i.e. visible 1 cycle after the tick cycle.
    - start_stop: go to PAUSE; the prescaler holds its value.
    - inc_* are ignored.
  - PAUSE:
    - start_stop: return to RUN, resuming the prescaler from its held value.
    - Time holds; inc_* are ignored.
  - DONE:
    - alarm=1 and time holds.
    - start_stop or clear: go to IDLE. start_stop keeps the time; clear zeroes it.
- Count up, on tick:
  - sec 59 -> 0 with minute +1.
  - At MAX_MIN:59 the time stays MAX_MIN:59 and state goes to DONE.
- Count down, on tick:
  - sec 0 -> 59 with minute -1.
  - The tick that produces 00:00 also moves state to DONE.
- clear, in any state: counter_out=0, prescaler=0, go to IDLE.
- Simultaneous events:
  - clear beats start_stop, which beats the tick.
  - start_stop in the same cycle as a tick in RUN: the tick is applied and state goes to PAUSE.
- Arithmetic:
  - All field arithmetic is 6-bit unsigned, with no intermediate wider values.
  - Field values above 59 are never produced.
- Outputs are registered, with no combinational path from input to output.

Decomposition:
- Shared package timer_pkg:
  - state enum timer_state_t {IDLE, RUN, PAUSE, DONE}
  - localparams SEC_MAX=59, FIELD_W=6, TIME_W=12
- One sub-module, tick_gen: the prescaler with inputs clk, nrst, en, clr and output tick. It is reused by future display-scan logic.
- The FSM and mm:ss arithmetic stay in timer_ctrl.

Test Plan:
- Set: reset, then inc_min x3 and inc_sec x65 -> counter_out = {6'd3, 6'd5}. Seconds wrap without carry.
- Stopwatch carry: TICK_DIV=4, mode_down=0, set 00:58, start -> after 2 ticks (8 cycles plus 1) counter_out = {1, 0}; running=1.
- Countdown to alarm: mode_down=1, set 01:00, start -> 1 tick gives 00:59. After 60 ticks counter_out=0, alarm=1, running=0 in the same cycle.
- Pause/resume:
  - Pause 2 cycles into a tick period and hold 20 cycles: time unchanged.
  - Resume: next update comes exactly 2 cycles later.
- Priority: assert clear and start_stop together in RUN -> IDLE, counter_out=0. Assert nrst=0 mid-RUN -> all outputs 0 on the next edge.
- Edge cases:
  - Countdown start at 00:00 -> DONE immediately, alarm=1.
  - Stopwatch at 59:59 -> holds 59:59, alarm=1.
